// File: rtl/ltc2308_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ltc2308_pkg
// Function : Shared types, constants and channel decode for the LTC2308 responder
// Revision : 1.0
// ============================================================================
package ltc2308_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        READY   = 2'd2,
        SHIFT   = 2'd3
    } state_t;

    localparam int CFG_BITS  = 6;
    localparam int DATA_BITS = 12;
    localparam int NUM_CHAN  = 8;

    localparam logic [CFG_BITS-1:0] CFG_RESET = 6'b100010;

    // Config word layout is {S/D, O/S, S1, S0, UNI, SLP}; channel is {S1, S0, O/S}.
    function automatic logic [2:0] cfg2chan(input logic [CFG_BITS-1:0] cfg);
        return {cfg[3], cfg[2], cfg[4]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge
// Function : 2-FF synchronizer with registered rise/fall pulses and aligned level
// Revision : 1.0
// ============================================================================
module sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic dly_q;
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= sig_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
            rise_q <= sync_q & ~dly_q;
            fall_q <= ~sync_q & dly_q;
        end
    end

    // dly_q changes on the same clk as the pulses, so level and edge agree.
    assign level_o = dly_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule
`default_nettype wire

// File: rtl/ltc2308_responder.sv
`default_nettype none
// ============================================================================
// Module   : ltc2308_responder
// Function : Slave-side LTC2308 ADC emulator driving SDO from a parallel sample bus
// Revision : 1.0
// ============================================================================
module ltc2308_responder
    import ltc2308_pkg::*;
#(
    parameter int CONV_CYCLES = 80
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DATA_BITS*NUM_CHAN-1:0] chan_data,
    input  logic                          ADC_CONVST,
    input  logic                          ADC_SCK,
    input  logic                          ADC_SDI,
    output logic                          ADC_SDO,
    output logic                          busy,
    output logic [CFG_BITS-1:0]           cfg,
    output logic                          frame_done
);

    localparam logic [9:0] c_conv_load = 10'(CONV_CYCLES - 1);

    logic conv_lvl;
    logic conv_rise;
    logic conv_fall;
    logic sck_lvl;
    logic sck_rise;
    logic sck_fall;
    logic sdi_lvl;
    logic sdi_rise;
    logic sdi_fall;
    logic unused_edges;

    sync_edge u_sync_convst (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_i   (ADC_CONVST),
        .level_o (conv_lvl),
        .rise_o  (conv_rise),
        .fall_o  (conv_fall)
    );

    sync_edge u_sync_sck (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_i   (ADC_SCK),
        .level_o (sck_lvl),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    sync_edge u_sync_sdi (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_i   (ADC_SDI),
        .level_o (sdi_lvl),
        .rise_o  (sdi_rise),
        .fall_o  (sdi_fall)
    );

    assign unused_edges = &{1'b0, conv_fall, sck_lvl, sdi_rise, sdi_fall};

    logic [DATA_BITS-1:0] chan_word [NUM_CHAN];

    for (genvar k = 0; k < NUM_CHAN; k++) begin : g_chan
        assign chan_word[k] = chan_data[DATA_BITS*k +: DATA_BITS];
    end

    state_t               state_q,    state_d;
    logic [9:0]           cnt_q,      cnt_d;
    logic [DATA_BITS-1:0] result_q,   result_d;
    logic [CFG_BITS-1:0]  cfg_q,      cfg_d;
    logic [CFG_BITS-1:0]  cfg_sr_q,   cfg_sr_d;
    logic [2:0]           rise_cnt_q, rise_cnt_d;
    logic [3:0]           fall_cnt_q, fall_cnt_d;
    logic                 sdo_q,      sdo_d;
    logic                 busy_q,     busy_d;
    logic                 done_q,     done_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            result_q   <= '0;
            cfg_q      <= CFG_RESET;
            cfg_sr_q   <= '0;
            rise_cnt_q <= '0;
            fall_cnt_q <= '0;
            sdo_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            cfg_q      <= cfg_d;
            cfg_sr_q   <= cfg_sr_d;
            rise_cnt_q <= rise_cnt_d;
            fall_cnt_q <= fall_cnt_d;
            sdo_q      <= sdo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        cfg_d      = cfg_q;
        cfg_sr_d   = cfg_sr_q;
        rise_cnt_d = rise_cnt_q;
        fall_cnt_d = fall_cnt_q;
        sdo_d      = sdo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        // A CONVST rise outranks any SCK edge arriving in the same clk.
        if (conv_rise && (state_q != CONVERT)) begin
            result_d   = chan_word[cfg2chan(cfg_q)];
            cnt_d      = c_conv_load;
            busy_d     = 1'b1;
            sdo_d      = 1'b0;
            rise_cnt_d = '0;
            fall_cnt_d = '0;
            state_d    = CONVERT;
        end else begin
            unique case (state_q)
                IDLE: begin
                    sdo_d = 1'b0;
                end
                CONVERT: begin
                    if (cnt_q == '0) begin
                        busy_d  = 1'b0;
                        state_d = READY;
                    end else begin
                        cnt_d = cnt_q - 10'd1;
                    end
                end
                READY: begin
                    if (conv_lvl) begin
                        sdo_d = 1'b0;
                    end else begin
                        sdo_d = result_q[DATA_BITS-1];
                        if (sck_rise) begin
                            cfg_sr_d   = {cfg_sr_q[CFG_BITS-2:0], sdi_lvl};
                            rise_cnt_d = 3'd1;
                            state_d    = SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (conv_lvl) begin
                        sdo_d = 1'b0;
                    end else begin
                        if (sck_rise && (rise_cnt_q < 3'(CFG_BITS))) begin
                            cfg_sr_d   = {cfg_sr_q[CFG_BITS-2:0], sdi_lvl};
                            rise_cnt_d = rise_cnt_q + 3'd1;
                            if (rise_cnt_q == 3'(CFG_BITS - 1)) begin
                                cfg_d = {cfg_sr_q[CFG_BITS-2:0], sdi_lvl};
                            end
                        end
                        if (sck_fall) begin
                            if (fall_cnt_q == 4'(DATA_BITS - 1)) begin
                                sdo_d      = 1'b0;
                                done_d     = 1'b1;
                                fall_cnt_d = '0;
                                state_d    = IDLE;
                            end else begin
                                fall_cnt_d = fall_cnt_q + 4'd1;
                                result_d   = {result_q[DATA_BITS-2:0], 1'b0};
                                sdo_d      = result_q[DATA_BITS-2];
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign ADC_SDO    = sdo_q;
    assign busy       = busy_q;
    assign cfg        = cfg_q;
    assign frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ltc2308_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ltc2308_responder
// Function : Self-checking bench for the LTC2308 responder against a frame-level model
// Revision : 1.0
// ============================================================================
module tb_ltc2308_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [95:0] chan_data;
    logic        ADC_CONVST;
    logic        ADC_SCK;
    logic        ADC_SDI;
    wire         ADC_SDO;
    wire         busy;
    wire  [5:0]  cfg;
    wire         frame_done;

    ltc2308_responder #(.CONV_CYCLES(80)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chan_data  (chan_data),
        .ADC_CONVST (ADC_CONVST),
        .ADC_SCK    (ADC_SCK),
        .ADC_SDI    (ADC_SDI),
        .ADC_SDO    (ADC_SDO),
        .busy       (busy),
        .cfg        (cfg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int          checks     = 0;
    int          errors     = 0;
    int          done_total = 0;
    int          vals [8];
    logic [5:0]  model_cfg;
    logic [11:0] exp_word;

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_total <= done_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_val(input int k, input int v);
        vals[k] = v;
        chan_data[k*12 +: 12] = 12'(v);
    endtask

    task automatic apply_data();
        for (int k = 0; k < 8; k++) set_val(k, int'($urandom_range(0, 4095)));
    endtask

    // Channel number from the datasheet bit meanings: S1 weighs 4, S0 weighs 2, O/S weighs 1.
    function automatic int model_chan(input logic [5:0] c);
        return (c[3] ? 4 : 0) + (c[2] ? 2 : 0) + (c[4] ? 1 : 0);
    endfunction

    task automatic convert(input int repulse_at);
        int len;
        bit seen;
        exp_word   = 12'(vals[model_chan(model_cfg)]);
        ADC_CONVST = 1'b1;
        wait_clk(2);
        ADC_CONVST = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (busy === 1'b1) seen = 1'b1;
            else wait_clk(1);
        end
        check("busy_rise", 32'(seen), 32'd1);
        if (seen) begin
            len = 0;
            while (busy === 1'b1 && len < 400) begin
                if (len == repulse_at)     ADC_CONVST = 1'b1;
                if (len == repulse_at + 2) ADC_CONVST = 1'b0;
                len++;
                wait_clk(1);
            end
            check("busy_len", 32'(len), 32'd80);
        end
        ADC_CONVST = 1'b0;
        wait_clk(6);
    endtask

    task automatic shift(input logic [5:0] sdi, input int ncyc);
        int          d0;
        logic [11:0] word;
        d0   = done_total;
        word = '0;
        for (int i = 0; i < ncyc; i++) begin
            ADC_SDI = (i < 6) ? sdi[5-i] : 1'($urandom_range(0, 1));
            wait_clk(6);
            if (i < 12) word = {word[10:0], ADC_SDO};
            ADC_SCK = 1'b1;
            wait_clk(6);
            if (i == 5) begin
                model_cfg = sdi;
                check("cfg_capture", 32'(cfg), 32'(model_cfg));
            end
            ADC_SCK = 1'b0;
            wait_clk(6);
        end
        if (ncyc >= 12) begin
            check("sdo_word", 32'(word), 32'(exp_word));
            check("frame_done_pulses", 32'(done_total - d0), 32'd1);
            check("sdo_idle", 32'(ADC_SDO), 32'd0);
        end
    endtask

    initial begin
        logic [5:0] sdi_k;
        logic [2:0] kb;
        int         len;

        reset_n    = 1'b0;
        ADC_CONVST = 1'b0;
        ADC_SCK    = 1'b0;
        ADC_SDI    = 1'b0;
        chan_data  = '0;
        model_cfg  = 6'b100010;
        exp_word   = '0;
        apply_data();
        wait_clk(3);
        check("reset_sdo",  32'(ADC_SDO),    32'd0);
        check("reset_busy", 32'(busy),       32'd0);
        check("reset_cfg",  32'(cfg),        32'h22);
        check("reset_done", 32'(frame_done), 32'd0);
        reset_n = 1'b1;
        wait_clk(2);

        // Basic frame from ch0
        set_val(0, 12'hA5C);
        convert(-1);
        shift(6'b100010, 12);

        // One-frame config pipeline
        set_val(1, 12'h123);
        set_val(0, 12'h777);
        convert(-1);
        shift(6'b110010, 12);
        convert(-1);
        shift(6'b100010, 12);

        // Sweep every channel select; one frame runs extra SCK cycles past the 12th
        for (int k = 0; k < 8; k++) begin
            kb    = 3'(k);
            sdi_k = {1'($urandom_range(0, 1)), kb, 2'($urandom_range(0, 3))};
            apply_data();
            convert(-1);
            shift(sdi_k, (k == 3) ? 14 : 12);
        end
        apply_data();
        convert(-1);
        shift(6'b100010, 12);

        // CONVST re-pulsed mid-conversion
        apply_data();
        convert(40);
        shift(6'b100010, 12);

        // CONVST re-pulsed after five SCK cycles: frame restarts, cfg held
        apply_data();
        convert(-1);
        shift(6'b111110, 5);
        apply_data();
        convert(-1);
        check("restart_cfg", 32'(cfg), 32'(model_cfg));
        shift(6'b100110, 12);

        // Reset pulse in the middle of a frame with SDO driving ones
        set_val(model_chan(model_cfg), 12'hFFF);
        convert(-1);
        shift(6'b101110, 8);
        reset_n = 1'b0;
        wait_clk(1);
        check("midreset_sdo",  32'(ADC_SDO), 32'd0);
        check("midreset_busy", 32'(busy),    32'd0);
        check("midreset_cfg",  32'(cfg),     32'h22);
        reset_n   = 1'b1;
        model_cfg = 6'b100010;
        wait_clk(2);
        apply_data();
        convert(-1);
        shift(6'b100010, 12);

        // CONVST rise lands with the 6th SCK rise: the bit is dropped, conversion starts
        apply_data();
        convert(-1);
        shift(6'b110110, 5);
        exp_word   = 12'(vals[model_chan(model_cfg)]);
        ADC_SDI    = 1'b0;
        ADC_SCK    = 1'b1;
        ADC_CONVST = 1'b1;
        wait_clk(2);
        ADC_CONVST = 1'b0;
        wait_clk(4);
        check("coincident_busy", 32'(busy), 32'd1);
        check("coincident_cfg",  32'(cfg),  32'(model_cfg));
        ADC_SCK = 1'b0;
        len = 0;
        while (busy === 1'b1 && len < 400) begin
            len++;
            wait_clk(1);
        end
        check("coincident_busy_end", 32'(busy), 32'd0);
        wait_clk(6);
        shift(6'b100010, 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ltc2308_responder.md
# ltc2308_responder

Synthesizable slave-side emulator of the LTC2308 8-channel 12-bit SPI ADC. It samples ADC_CONVST, ADC_SCK and ADC_SDI from the master and drives ADC_SDO with the LTC2308 frame protocol, including the one-frame config pipeline. It returns per-channel values from a parallel input bus. It is used for on-board loopback of adcinterface, with SDO routed back to its own pins, and as the ADC model in the system bench.

## Interface
- CONV_CYCLES, 80: conversion time in clk cycles (1.6 us at 50 MHz); legal range 1..1023.
- clk  input  1  system clock (CLOCK_50).
- reset_n  input  1  reset. Synchronous and active-low: applied on posedge clk when low.
- chan_data  input  96  sample values; channel k occupies [12k+11:12k]. Sampled when a conversion starts.
- ADC_CONVST  input  1  conversion start, asynchronous to clk.
- ADC_SCK  input  1  serial clock, asynchronous to clk.
- ADC_SDI  input  1  config bits, MSB first: S/D, O/S, S1, S0, UNI, SLP.
- ADC_SDO  output  1  result data, MSB first; reset 0.
- busy  output  1  conversion in progress; reset 0.
- cfg  output  6  last complete config word captured; reset 6'b100010 (single-ended, CH0, unipolar).
- frame_done  output  1  one-clk pulse when the 12th SDO bit has been shifted out; reset 0.

## Operation
- ADC_CONVST, ADC_SCK and ADC_SDI each pass through a 2-FF synchronizer. Rise/fall pulses are derived from the synced copies. All logic runs on the synced versions.
- Channel decode: chan = {S1, S0, O/S}. S/D, UNI and SLP are recorded in cfg and otherwise ignored.
- States:
  - IDLE (reset state).
  - CONVERT.
  - READY.
  - SHIFT.
- CONVST rise, in IDLE, READY or SHIFT:
  - load result <= chan_data slice for the chan decoded from cfg;
  - load counter <= CONV_CYCLES-1;
  - set busy=1, ADC_SDO=0, and go to CONVERT.
  - Any partial frame is abandoned: bit counters are cleared, cfg is unchanged.
- CONVERT: counter decrements each clk. At 0: busy=0, go to READY. CONVST rise here is ignored.
- READY: ADC_SDO = result[11] whenever synced CONVST is low. Go to SHIFT on the first SCK rise with CONVST low.
- SHIFT (CONVST low):
  - SCK rise: shift SDI into cfg_sr while the rise count is below 6. On the 6th rise, cfg <= cfg_sr.
  - SCK fall: advance the SDO bit index.
  - After the 12th fall: ADC_SDO=0, pulse frame_done, go to IDLE.
- Pipeline: the config captured in frame N selects the channel converted at the CONVST rise that starts frame N+1.
- If CONVST is high in READY or SHIFT, SCK edges are ignored and ADC_SDO=0.
- Simultaneous CONVST rise and SCK edge in the same clk: the CONVST rise wins and the SCK edge is dropped.
- Fewer than 6 SCK rises before the next CONVST: cfg is unchanged.
- More than 12 SCK falls: the extra edges are ignored, because the block is already in IDLE.
- reset_n low mid-operation: all state, outputs and cfg go to their reset values on that posedge clk.

## Timing
- Pin-to-action latency: 3 clk (2 synchronizer stages plus the edge register). Master SCK half-period must be at least 4 clk; adcinterface runs SCK at clk/65536.
- busy rises 1 clk after the CONVST rise pulse and stays high for exactly CONV_CYCLES clk.
- ADC_SDO changes 1 clk after the SCK fall pulse, i.e. 4 clk after the pin edge.
- frame_done is asserted in the same clk that ADC_SDO returns to 0.
- All outputs are registered.

## Structure
- ltc2308_pkg holds:
  - state_t enum {IDLE, CONVERT, READY, SHIFT};
  - localparams CFG_BITS=6, DATA_BITS=12, NUM_CHAN=8, CFG_RESET=6'b100010;
  - function cfg2chan(cfg) returning the 3-bit channel.
- One sub-module, sync_edge: 2-FF synchronizer plus registered rise/fall pulses, same clk/reset_n. Instantiated three times.

## Test plan
- Reset, then CONVST pulse, with chan_data ch0=12'hA5C. Required:
  - busy high for 80 clk;
  - SDO bits over 12 SCK falls read 1010_0101_1100;
  - frame_done is one pulse.
- Frame 1 SDI=6'b110010 (O/S=1, chan 1); ch1=12'h123, ch0=12'h777. Required: frame 1 returns 12'h777, frame 2 returns 12'h123, cfg=6'b110010 after the 6th rise.
- Sweep all 8 configs (O/S, S1, S0 = 000…111). Required: channel order 0,2,4,6,1,3,5,7 returns the matching chan_data slices.
- CONVST re-pulsed at clk 40 of a conversion: ignored, busy still lasts 80 clk total. CONVST re-pulsed after 5 SCK edges of SHIFT: the frame restarts, cfg is unchanged.
- reset_n low for 1 clk mid-SHIFT. Required: SDO=0, busy=0, cfg=6'b100010, and the next frame converts ch0.
- CONVST rise coincident with an SCK rise pulse. Required: the SDI bit is not captured and a conversion starts.
